// File: rtl/tft_pkg.sv
// Shared TFT definitions: RGB565 colours, default panel size and the fill FSM state type.
package tft_pkg;

    localparam int unsigned H_ACT_DEF = 480;
    localparam int unsigned V_ACT_DEF = 272;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] BLUE    = 16'h001f;
    localparam logic [15:0] GREEN   = 16'h07e0;
    localparam logic [15:0] CYAN    = 16'h07ff;
    localparam logic [15:0] RED     = 16'hf800;
    localparam logic [15:0] MAGENTA = 16'hf81f;
    localparam logic [15:0] YELLOW  = 16'hffe0;
    localparam logic [15:0] WHITE   = 16'hffff;

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} fill_state_t;

endpackage

// File: rtl/frame_pixel_counter.sv
// Raster x/y counter for one active frame; last_pixel flags the final pixel position.
module frame_pixel_counter #(
    parameter int unsigned H_ACT = 480,
    parameter int unsigned V_ACT = 272,
    parameter int unsigned XW    = $clog2(H_ACT),
    parameter int unsigned YW    = $clog2(V_ACT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_pixel
);

    logic x_last;
    logic y_last;

    assign x_last     = (x == XW'(H_ACT - 1));
    assign y_last     = (y == YW'(V_ACT - 1));
    assign last_pixel = x_last && y_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_fill_writer.sv
// Writes one full frame of each new colour into the SDRAM write FIFO, ping-ponging two buffers.
// Build option GRID_OVERLAY_EN overlays a white 16-pixel grid on the written pixels.
module frame_fill_writer
    import tft_pkg::*;
#(
    parameter int unsigned       H_ACT  = H_ACT_DEF,
    parameter int unsigned       V_ACT  = V_ACT_DEF,
    parameter int unsigned       ADDR_W = 24,
    parameter logic [ADDR_W-1:0] BASE0  = ADDR_W'(24'h000000),
    parameter logic [ADDR_W-1:0] BASE1  = ADDR_W'(24'h020000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pix_data,
    input  logic              pix_en,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [15:0]       wr_data,
    output logic              wr_load,
    output logic [ADDR_W-1:0] wr_base,
    output logic              rd_buf_sel,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned XW = $clog2(H_ACT);
    localparam int unsigned YW = $clog2(V_ACT);

    fill_state_t   state;
    logic [15:0]   color;
    logic [15:0]   next_color;
    logic          have_color;
    logic          pend;
    logic          wbuf;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last_pixel;
    logic          trigger;
    logic [15:0]   pixel;

    assign trigger = pix_en && (!have_color || (pix_data != color));
    assign wr_en   = (state == FILL) && !wr_full;
    assign wr_data = (state == FILL) ? pixel : 16'h0000;

`ifdef GRID_OVERLAY_EN
    logic [15:0] x16;
    logic [15:0] y16;
    assign x16   = 16'(x);
    assign y16   = 16'(y);
    assign pixel = ((x16[3:0] == 4'd0) || (y16[3:0] == 4'd0)) ? WHITE : color;
`else
    assign pixel = color;
`endif

    frame_pixel_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .XW    (XW),
        .YW    (YW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == LOAD),
        .advance    (wr_en),
        .x          (x),
        .y          (y),
        .last_pixel (last_pixel)
    );

    // Fill sequencer; wbuf flips on the last write so a DONE->LOAD hop already sees the next buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            color      <= 16'h0000;
            next_color <= 16'h0000;
            have_color <= 1'b0;
            pend       <= 1'b0;
            wbuf       <= 1'b0;
            wr_load    <= 1'b0;
            wr_base    <= BASE0;
            rd_buf_sel <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_load    <= 1'b0;
            frame_done <= 1'b0;
            if (trigger && (state != IDLE)) begin
                pend       <= 1'b1;
                next_color <= pix_data;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        color      <= pix_data;
                        have_color <= 1'b1;
                        wr_load    <= 1'b1;
                        wr_base    <= wbuf ? BASE1 : BASE0;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: state <= FILL;
                FILL: begin
                    if (wr_en && last_pixel) begin
                        frame_done <= 1'b1;
                        rd_buf_sel <= wbuf;
                        wbuf       <= ~wbuf;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (trigger || pend) begin
                        color   <= trigger ? pix_data : next_color;
                        pend    <= 1'b0;
                        wr_load <= 1'b1;
                        wr_base <= wbuf ? BASE1 : BASE0;
                        state   <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
